// File: rtl/srt_div_pkg.sv
// Shared types and constants for the SRT divider scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, FP32/quotient widths, default timeout, pointer helper.
package srt_div_pkg;

  localparam int FP32_W      = 32;
  localparam int QUO_W       = 24;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Round-robin successor of requester g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/srt_div_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req (request vector), ptr (search start) -> gnt (one-hot), idx (binary), any.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One spare bit so ptr+offset can exceed NREQ before the wrap subtraction.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(NREQ)) begin
        cand = cand - (IDX_W + 1)'(NREQ);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                    = 1'b1;
        idx                    = cand[IDX_W-1:0];
        gnt[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/srt_div_scheduler.sv
// Shares one iterative FP32 SRT divider core among NREQ requesters, round-robin.
// Latency: accept T -> core_start T+1; core_done D -> resp_valid D+1; timeout resp at start+TIMEOUT+1.
// Backpressure: one op in flight; response held until the winner's resp_ready, no grants meanwhile.
// Ports: req_* (per-requester request channel), resp_* (per-requester response channel,
//        shared result/err), core_* (start/done handshake to the divider core), busy.
module srt_div_scheduler
  import srt_div_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [FP32_W*NREQ-1:0]   req_dividend,
  input  logic [FP32_W*NREQ-1:0]   req_divisor,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready,
  output logic [QUO_W-1:0]         resp_result,
  output logic                     resp_err,
  output logic                     core_start,
  output logic [FP32_W-1:0]        core_dividend,
  output logic [FP32_W-1:0]        core_divisor,
  input  logic                     core_done,
  input  logic [QUO_W-1:0]         core_result,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q,  state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  gnt_q,    gnt_d;
  logic [FP32_W-1:0] dvd_q,    dvd_d;
  logic [FP32_W-1:0] dvs_q,    dvs_d;
  logic [QUO_W-1:0]  res_q,    res_d;
  logic              err_q,    err_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic              accept_ok;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Gate with rst so no handshake can complete while the block is being reset.
  assign accept_ok = (state_q == IDLE) && rst;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_ok && arb_any) begin
          gnt_d   = arb_idx;
          dvd_d   = req_dividend[FP32_W*int'(arb_idx) +: FP32_W];
          dvs_d   = req_divisor[FP32_W*int'(arb_idx) +: FP32_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_q counts completed WAIT cycles; the cycle where it would reach
        // TIMEOUT is the last one, and a done in that same cycle still wins.
        if (core_done) begin
          res_d   = core_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready[gnt_q]) begin
          rr_ptr_d = IDX_W'(rr_next(int'(gnt_q), NREQ));
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready     = accept_ok ? arb_gnt : '0;
  assign resp_valid    = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign resp_result   = res_q;
  assign resp_err      = err_q;
  assign core_start    = (state_q == ISSUE);
  assign core_dividend = dvd_q;
  assign core_divisor  = dvs_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_srt_div_scheduler.sv
// Directed bench for srt_div_scheduler with a behavioural divider core and response scoreboard.
// Latency: n/a.
// Backpressure: driven explicitly through resp_ready.
module tb_srt_div_scheduler;

  localparam int NREQ = 2;
  localparam int TO   = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*32-1:0]   req_dividend, req_divisor;
  logic [23:0]          resp_result, core_result;
  logic                 resp_err, core_start, core_done, busy;
  logic [31:0]          core_dividend, core_divisor;

  // Core-side inputs come from the behavioural core or from directed pulses.
  logic        mdl_done = 1'b0, tb_done = 1'b0;
  logic [23:0] mdl_result = '0, tb_result = '0;
  assign core_done   = mdl_done | tb_done;
  assign core_result = tb_done ? tb_result : mdl_result;

  int  checks = 0;
  int  errors = 0;
  int  core_lat = 10;
  bit  core_hang = 1'b0;
  bit  model_en = 1'b1;
  int  exp_mode = 0;        // 0: quotient of operands, 1: timeout, 2: exp_fixed
  logic [23:0] exp_fixed = '0;

  typedef struct { int idx; logic [23:0] res; logic err; } exp_t;
  exp_t sb[$];
  int   grant_q[$];

  srt_div_scheduler #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_done(core_done), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Normalised 24-bit mantissa quotient of two FP32 values.
  function automatic logic [23:0] mant_q(input logic [31:0] a, input logic [31:0] b);
    logic [48:0] ma, mb, q;
    ma = {25'd0, 1'b1, a[22:0]};
    mb = {25'd0, 1'b1, b[22:0]};
    q  = (ma << 23) / mb;
    if (q[23] == 1'b0) q = (ma << 24) / mb;
    return q[23:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt(); @(posedge clk); #2; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic wait_accept(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      smp();
      if (req_ready[idx]) begin ok = 1'b1; break; end
    end
  endtask

  // Called at the negedge of the core_start cycle; n = cycles until resp_valid[idx].
  task automatic wait_resp(input int idx, input int budget, output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= budget; i++) begin
      nxt(); smp();
      if (resp_valid[idx]) begin ok = 1'b1; n = i; break; end
    end
  endtask

  // Behavioural divider core: done pulse core_lat cycles after the start cycle.
  initial begin
    logic [31:0] a, b;
    forever begin
      @(posedge clk); #1;
      if (core_start && model_en && !core_hang) begin
        a = core_dividend; b = core_divisor;
        repeat (core_lat) @(posedge clk);
        #1; mdl_done = 1'b1; mdl_result = mant_q(a, b);
        @(posedge clk); #1; mdl_done = 1'b0;
      end
    end
  end

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  initial begin
    exp_t e;
    int   gi;
    wait (rst === 1'b1);
    forever begin
      smp();
      chk("req_ready_onehot", 32'(req_ready & (req_ready - 1'b1)), 32'd0);
      chk("resp_valid_onehot", 32'(resp_valid & (resp_valid - 1'b1)), 32'd0);
      if ((req_valid & req_ready) != '0) begin
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
        e.idx = gi;
        case (exp_mode)
          0:       begin e.res = mant_q(req_dividend[gi*32 +: 32], req_divisor[gi*32 +: 32]); e.err = 1'b0; end
          1:       begin e.res = '0; e.err = 1'b1; end
          default: begin e.res = exp_fixed; e.err = 1'b0; end
        endcase
        sb.push_back(e);
        grant_q.push_back(gi);
      end
      if ((resp_valid & resp_ready) != '0) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_resp_idx", 32'(resp_valid), 32'd1 << e.idx);
          chk("sb_resp_result", 32'(resp_result), 32'(e.res));
          chk("sb_resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ok;
    int          n, bad_v, bad_r, bad_b, bad_g;
    logic [23:0] held;

    // ---- reset state (requests asserted to prove req_ready is held low) ----
    req_valid = 2'b11; resp_ready = 2'b11;
    req_dividend = {32'h3F800000, 32'h40800000};
    req_divisor  = {32'h40400000, 32'h40000000};
    repeat (3) @(posedge clk);
    #2; smp();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_dividend", core_dividend, 32'd0);
    chk("rst_core_divisor", core_divisor, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nxt(); rst = 1'b1; req_valid = '0;

    // ---- single request: 4.0 / 2.0, core latency 10 ----
    nxt(); req_valid = 2'b01;
    wait_accept(0, 20, ok); chk("t1_accept", 32'(ok), 32'd1);
    nxt(); req_valid = '0; smp();
    chk("t1_core_start", 32'(core_start), 32'd1);
    chk("t1_core_dividend", core_dividend, 32'h40800000);
    chk("t1_core_divisor", core_divisor, 32'h40000000);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_resp(0, 40, ok, n);
    chk("t1_resp_seen", 32'(ok), 32'd1);
    chk("t1_start_to_resp", 32'(n), 32'd11);
    chk("t1_result", 32'(resp_result), 32'h800000);
    chk("t1_err", 32'(resp_err), 32'd0);
    nxt(); smp();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // ---- backpressure on requester 1 (1.0 / 3.0), requester 0 waiting ----
    nxt(); core_lat = 5; req_valid = 2'b10; resp_ready = 2'b01;
    wait_accept(1, 20, ok); chk("t2_accept", 32'(ok), 32'd1);
    nxt(); req_valid = 2'b01;
    req_dividend[31:0] = 32'h40400000; req_divisor[31:0] = 32'h40000000;
    smp();
    chk("t2_core_start", 32'(core_start), 32'd1);
    wait_resp(1, 30, ok, n);
    chk("t2_resp_seen", 32'(ok), 32'd1);
    chk("t2_start_to_resp", 32'(n), 32'd6);
    chk("t2_result", 32'(resp_result), 32'hAAAAAA);
    held = resp_result;
    bad_v = 0; bad_r = 0; bad_b = 0; bad_g = 0;
    for (int i = 0; i < 20; i++) begin
      nxt(); smp();
      if (resp_valid !== 2'b10) bad_v++;
      if (resp_result !== held) bad_r++;
      if (busy !== 1'b1) bad_b++;
      if (req_ready !== '0) bad_g++;
    end
    chk("t2_hold_valid", 32'(bad_v), 32'd0);
    chk("t2_hold_result", 32'(bad_r), 32'd0);
    chk("t2_hold_busy", 32'(bad_b), 32'd0);
    chk("t2_no_grant", 32'(bad_g), 32'd0);

    // ---- timeout on requester 0 (core never answers), response held ----
    core_hang = 1'b1; exp_mode = 1;
    nxt(); resp_ready = 2'b10;
    wait_accept(0, 10, ok); chk("t3_accept", 32'(ok), 32'd1);
    nxt(); req_valid = '0; smp();
    chk("t3_core_start", 32'(core_start), 32'd1);
    wait_resp(0, 100, ok, n);
    chk("t3_resp_seen", 32'(ok), 32'd1);
    chk("t3_start_to_resp", 32'(n), 32'(TO + 1));
    chk("t3_result", 32'(resp_result), 32'd0);
    chk("t3_err", 32'(resp_err), 32'd1);
    nxt(); tb_done = 1'b1; tb_result = 24'h777777; smp();
    chk("t3_late_valid", 32'(resp_valid), 32'd1);
    nxt(); tb_done = 1'b0; smp();
    chk("t3_late_result", 32'(resp_result), 32'd0);
    chk("t3_late_err", 32'(resp_err), 32'd1);
    chk("t3_late_valid2", 32'(resp_valid), 32'd1);
    nxt(); resp_ready = 2'b11; smp();
    nxt(); smp();
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // ---- reset in the middle of WAIT ----
    nxt(); req_valid = 2'b10;
    wait_accept(1, 10, ok); chk("t4_accept", 32'(ok), 32'd1);
    nxt(); req_valid = '0;
    repeat (5) nxt();
    rst = 1'b0; sb.delete();
    nxt(); rst = 1'b1; smp();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_req_ready", 32'(req_ready), 32'd0);
    chk("t4_resp_valid", 32'(resp_valid), 32'd0);
    chk("t4_resp_err", 32'(resp_err), 32'd0);
    chk("t4_core_start", 32'(core_start), 32'd0);
    chk("t4_core_dividend", core_dividend, 32'd0);
    chk("t4_core_divisor", core_divisor, 32'd0);
    bad_v = 0;
    for (int i = 0; i < TO + 8; i++) begin
      nxt(); smp();
      if (resp_valid !== '0 || core_start !== 1'b0) bad_v++;
    end
    chk("t4_no_resp", 32'(bad_v), 32'd0);

    // ---- fairness from the reset pointer: both requesters always valid ----
    core_hang = 1'b0; exp_mode = 0; core_lat = 3; grant_q.delete();
    nxt(); req_valid = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      smp();
      if (grant_q.size() >= 4) begin ok = 1'b1; break; end
      nxt();
    end
    chk("t5_four_grants", 32'(ok), 32'd1);
    nxt(); req_valid = '0;
    if (grant_q.size() >= 4) begin
      chk("t5_grant0", 32'(grant_q[0]), 32'd0);
      chk("t5_grant1", 32'(grant_q[1]), 32'd1);
      chk("t5_grant2", 32'(grant_q[2]), 32'd0);
      chk("t5_grant3", 32'(grant_q[3]), 32'd1);
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      smp();
      if (sb.size() == 0) begin ok = 1'b1; break; end
      nxt();
    end
    chk("t5_drained", 32'(ok), 32'd1);

    // ---- done during ISSUE is ignored; the second done completes ----
    model_en = 1'b0; exp_mode = 2; exp_fixed = 24'h654321;
    nxt(); req_valid = 2'b01;
    wait_accept(0, 10, ok); chk("t6_accept", 32'(ok), 32'd1);
    nxt(); req_valid = '0; tb_done = 1'b1; tb_result = 24'h123456; smp();
    chk("t6_core_start", 32'(core_start), 32'd1);
    nxt(); tb_done = 1'b0;
    bad_v = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (resp_valid !== '0) bad_v++;
      nxt();
    end
    chk("t6_issue_done_ignored", 32'(bad_v), 32'd0);
    tb_done = 1'b1; tb_result = 24'h654321; smp();
    nxt(); tb_done = 1'b0; smp();
    chk("t6_resp_valid", 32'(resp_valid), 32'd1);
    chk("t6_result", 32'(resp_result), 32'h654321);
    chk("t6_err", 32'(resp_err), 32'd0);

    // ---- done in the very cycle the counter reaches TIMEOUT ----
    exp_fixed = 24'h0ABCDE;
    nxt(); req_valid = 2'b10;
    wait_accept(1, 10, ok); chk("t7_accept", 32'(ok), 32'd1);
    nxt(); req_valid = '0; smp();
    chk("t7_core_start", 32'(core_start), 32'd1);
    repeat (TO) nxt();
    tb_done = 1'b1; tb_result = 24'h0ABCDE; smp();
    chk("t7_still_wait", 32'(resp_valid), 32'd0);
    nxt(); tb_done = 1'b0; smp();
    chk("t7_resp_valid", 32'(resp_valid), 32'd2);
    chk("t7_err", 32'(resp_err), 32'd0);
    chk("t7_result", 32'(resp_result), 32'h0ABCDE);

    nxt(); nxt(); smp();
    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
